// File: rtl/aes_dec_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 decryption sequencer.
package aes_dec_pkg;

  localparam int NR = 10;  // AES-128 round count
  localparam int KW = 4;   // round-key index width

  typedef logic [127:0] state_t;

  typedef enum logic [2:0] {
    IDLE,
    ROUND,
    LAST,
    FINAL,
    DONE
  } fsm_t;

  localparam logic [KW-1:0] ROUND_FIRST_KEY = 4'd10;
  localparam logic [KW-1:0] LAST_KEY        = 4'd1;
  localparam logic [KW-1:0] FINAL_KEY       = 4'd0;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, a);
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine transform, then invert in the field.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] x;
    x = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(x);
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: AddRoundKey, InvSubBytes, InvShiftRows and
// (unless last) InvMixColumns. Byte 0 of the state is bits [127:120], column-major.
module aes_inv_round
  import aes_dec_pkg::*;
(
  input  state_t     state_in,
  input  state_t     round_key,
  input  logic       last,
  output state_t     state_out
);

  state_t     ark;
  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  // Inverse round datapath, one full round per evaluation.
  always_comb begin
    // NOTE: every variable written here gets a value on every path (defaults
    // first, then full-coverage loops) so no latch is inferred.
    state_out = '0;
    ark       = state_in ^ round_key;
    for (int i = 0; i < 16; i++) sb[i] = inv_sbox(ark[127-8*i -: 8]);
    // Row r rotates right by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c + 4 - r) % 4) + r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = gf_mul(sr[4*c], 8'h0e) ^ gf_mul(sr[4*c+1], 8'h0b) ^
                  gf_mul(sr[4*c+2], 8'h0d) ^ gf_mul(sr[4*c+3], 8'h09);
      mc[4*c+1] = gf_mul(sr[4*c], 8'h09) ^ gf_mul(sr[4*c+1], 8'h0e) ^
                  gf_mul(sr[4*c+2], 8'h0b) ^ gf_mul(sr[4*c+3], 8'h0d);
      mc[4*c+2] = gf_mul(sr[4*c], 8'h0d) ^ gf_mul(sr[4*c+1], 8'h09) ^
                  gf_mul(sr[4*c+2], 8'h0e) ^ gf_mul(sr[4*c+3], 8'h0b);
      mc[4*c+3] = gf_mul(sr[4*c], 8'h0b) ^ gf_mul(sr[4*c+1], 8'h0d) ^
                  gf_mul(sr[4*c+2], 8'h09) ^ gf_mul(sr[4*c+3], 8'h0e);
    end
    for (int i = 0; i < 16; i++) state_out[127-8*i -: 8] = last ? sr[i] : mc[i];
  end

endmodule

// File: rtl/aes_dec_sequencer.sv
// Iterative AES-128 decryption controller. One inverse round per clock, round
// keys fetched 10 down to 0. Because AddRoundKey precedes InvMixColumns in each
// round, the key store must hold the equivalent-inverse-cipher schedule: keys
// 1..9 pre-transformed by InvMixColumns, keys 0 and 10 unchanged.
module aes_dec_sequencer #(
  parameter int NR = aes_dec_pkg::NR,
  parameter int KW = aes_dec_pkg::KW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  ciphertext,
  input  logic          key_valid,
  output logic [KW-1:0] key_idx,
  input  logic [127:0]  round_key,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  plaintext,
  output logic          abort
);

  import aes_dec_pkg::*;

  // Counter value of the final full round (key 2).
  localparam logic [3:0] LAST_ROUND_CNT = 4'(NR - 2);

  fsm_t       state;
  logic [3:0] cnt;
  state_t     state_reg;
  state_t     round_out;
  logic       last_round;

  assign last_round = (state == LAST);
  assign in_ready   = (state == IDLE) && key_valid && !rst;

  aes_inv_round u_inv_round (
    .state_in  (state_reg),
    .round_key (round_key),
    .last      (last_round),
    .state_out (round_out)
  );

  // Round-key index decoded from registered state only, so it is stable all cycle.
  always_comb begin
    key_idx = ROUND_FIRST_KEY;
    case (state)
      ROUND:       key_idx = ROUND_FIRST_KEY - cnt;
      LAST:        key_idx = LAST_KEY;
      FINAL, DONE: key_idx = FINAL_KEY;
      default:     key_idx = ROUND_FIRST_KEY;
    endcase
  end

  // Sequencer FSM with registered datapath state and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      state_reg <= '0;
      plaintext <= '0;
      out_valid <= 1'b0;
      abort     <= 1'b0;
    end else begin
      abort <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && key_valid) begin
            state_reg <= ciphertext;
            cnt       <= 4'd0;
            state     <= ROUND;
          end
        end
        ROUND: begin
          if (!key_valid) begin
            state <= IDLE;
            cnt   <= 4'd0;
            abort <= 1'b1;
          end else if (cnt > LAST_ROUND_CNT) begin
            // Unreachable count: recover quietly.
            state <= IDLE;
            cnt   <= 4'd0;
          end else begin
            state_reg <= round_out;
            if (cnt == LAST_ROUND_CNT) begin
              cnt   <= 4'd0;
              state <= LAST;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        LAST: begin
          if (!key_valid) begin
            state <= IDLE;
            abort <= 1'b1;
          end else begin
            state_reg <= round_out;
            state     <= FINAL;
          end
        end
        FINAL: begin
          if (!key_valid) begin
            state <= IDLE;
            abort <= 1'b1;
          end else begin
            plaintext <= state_reg ^ round_key;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // The held result survives key_valid dropping; only the consumer frees it.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec_sequencer.sv
// Self-checking bench for aes_dec_sequencer. The reference is a forward AES-128
// encryptor: random plaintexts are encrypted here and the DUT must recover them.
module tb_aes_dec_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic         key_valid;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;
  logic         abort;

  logic [127:0] ek [0:10];   // encryption round keys
  logic [127:0] dk [0:10];   // key store contents presented to the DUT
  logic [7:0]   sbox [0:255];
  int           n_cmp = 0;
  int           n_fail = 0;
  int           cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign round_key = (key_idx <= 4'd10) ? dk[key_idx] : '0;

  aes_dec_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .key_valid  (key_valid),
    .key_idx    (key_idx),
    .round_key  (round_key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext),
    .abort      (abort)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Forward S-box from its definition: brute-force field inverse, then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Column mix with coefficient row {2,3,1,1} (forward) or {e,b,d,9} (inverse).
  function automatic logic [127:0] mix(input logic [127:0] s, input bit inverse);
    logic [7:0]   coef [4];
    logic [127:0] o;
    logic [7:0]   acc;
    coef = inverse ? '{8'h0e, 8'h0b, 8'h0d, 8'h09} : '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc ^= gm(s[127-8*(4*c+j) -: 8], coef[(j - r + 4) % 4]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    end
    return o;
  endfunction

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rcon, 24'h0};
        rcon = gm(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) begin
      ek[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      dk[r] = (r == 0 || r == 10) ? ek[r] : mix(ek[r], 1'b1);
    end
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s;
    logic [127:0] t;
    s = pt ^ ek[0];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = sbox[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[127-8*(r+4*c) -: 8] = s[127-8*(r + 4*((c + r) % 4)) -: 8];
      s = (rnd < 10) ? mix(t, 1'b0) : t;
      s = s ^ ek[rnd];
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One block from offer to completed output handshake; called at a negedge.
  task automatic run_block(input logic [127:0] ct, input logic [127:0] exp, input int bp,
                           input bit detail, input bit hold, input logic [127:0] next_ct,
                           output int acc);
    bit got = 1'b0;
    out_ready  = (bp == 0);
    in_valid   = 1'b1;
    ciphertext = ct;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept", got, 1'b1);
    acc = cyc;
    @(negedge clk);
    if (hold) ciphertext = next_ct;
    else in_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (detail) check("key_idx", key_idx, (k <= 10) ? 10 - k : 0);
      if (detail || k >= 10) check("out_valid_latency", out_valid, k == 11);
    end
    check("plaintext", plaintext, exp);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_plaintext", plaintext, exp);
      check("bp_valid_ready", {out_valid, in_ready}, 2'b10);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("handshake_idle", {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] pt;
    logic [127:0] pt2;
    int a1;
    int a2;
    rst = 1'b1; in_valid = 1'b0; ciphertext = '0; key_valid = 1'b0; out_ready = 1'b0;
    build_sbox();
    set_key(128'h000102030405060708090a0b0c0d0e0f);
    key_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_key_idx", key_idx, 4'd10);
    check("rst_out_valid_abort", {out_valid, abort}, 2'b00);
    check("rst_plaintext", plaintext, '0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("idle_in_ready", in_ready, 1'b1);

    // FIPS-197 C.1 vector with full key_idx trace.
    run_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff,
              0, 1'b1, 1'b0, '0, a1);

    // Back-pressure for 20 cycles.
    pt = rand128();
    run_block(encrypt(pt), pt, 20, 1'b0, 1'b0, '0, a1);

    // Random keys and plaintexts.
    for (int n = 0; n < 3; n++) begin
      set_key(rand128());
      pt = rand128();
      run_block(encrypt(pt), pt, $urandom_range(0, 3), 1'b0, 1'b0, '0, a1);
    end

    // Back-to-back with in_valid held high.
    pt  = rand128();
    pt2 = rand128();
    run_block(encrypt(pt), pt, 0, 1'b0, 1'b1, encrypt(pt2), a1);
    run_block(encrypt(pt2), pt2, 0, 1'b0, 1'b0, '0, a2);
    check("b2b_interval", a2 - a1, 13);

    // Abort: key_valid drops during the 5th ROUND cycle.
    pt = rand128();
    in_valid = 1'b1; ciphertext = encrypt(pt); out_ready = 1'b1;
    #1 check("abort_accept", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    check("abort_pulse", {abort, out_valid, in_ready}, 3'b100);
    check("abort_key_idx", key_idx, 4'd10);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check("abort_quiet", {abort, out_valid, in_ready}, 3'b000);
    end
    key_valid = 1'b1;
    #1 check("abort_in_ready_back", in_ready, 1'b1);
    run_block(encrypt(pt), pt, 0, 1'b0, 1'b0, '0, a1);

    // Asynchronous reset during the 7th ROUND cycle.
    pt = rand128();
    in_valid = 1'b1; ciphertext = encrypt(pt);
    #1 check("rst_mid_accept", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_outputs", {out_valid, abort, in_ready}, 3'b000);
    check("rst_mid_key_idx", key_idx, 4'd10);
    check("rst_mid_plaintext", plaintext, '0);
    @(negedge clk);
    check("rst_mid_no_abort", abort, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_quiet", {out_valid, abort, in_ready}, 3'b001);
    run_block(encrypt(pt), pt, 1, 1'b0, 1'b0, '0, a1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
